// File: rtl/cpuclk_sched.sv
// Decides when the CPU runs from the high-speed clock versus the 2 MHz host clock and
// sequences the glitch-free switch handshake, dwell, ack timeout and divider changes.
module cpuclk_sched #(
  parameter int unsigned MIN_DWELL   = 4,
  parameter int unsigned ACK_TIMEOUT = 15,
  parameter logic [1:0]  DEFAULT_DIV = 2'b00
) (
  input  logic       lsclk_in,
  input  logic       rst_b,
  input  logic       fast_req,
  input  logic       slow_force,
  input  logic       cfg_wr,
  input  logic [2:0] cfg_wdata,
  input  logic       hsclk_selected,
  input  logic       lsclk_selected,
  output logic       hsclk_sel,
  output logic [1:0] cpuclk_div_sel,
  output logic       hs_active,
  output logic       switching,
  output logic       timeout_err,
  output logic [7:0] switch_count
);

  typedef enum logic [1:0] {LS_RUN, TO_HS, HS_RUN, TO_LS} state_t;

  localparam logic [7:0] TMO   = 8'(ACK_TIMEOUT);
  localparam logic [3:0] DWELL = 4'(MIN_DWELL);

  state_t     state;
  logic [1:0] hs_sync;
  logic       hs_ack;
  logic       enable;
  logic [1:0] div_pend;
  logic [7:0] timer;
  logic [3:0] dwell;
  logic       tmr_exp;

  assign hs_ack  = hs_sync[1];
  // Expiry on the edge that would take the timer to zero, i.e. ACK_TIMEOUT edges after entry.
  assign tmr_exp = (timer <= 8'd1);

  always_ff @(posedge lsclk_in or negedge rst_b)
    if (!rst_b) hs_sync <= 2'b00;
    else        hs_sync <= {hs_sync[0], hsclk_selected};

  always_ff @(posedge lsclk_in or negedge rst_b)
    if (!rst_b) begin
      enable         <= 1'b0;
      div_pend       <= DEFAULT_DIV;
      cpuclk_div_sel <= DEFAULT_DIV;
    end else begin
      if (cfg_wr) begin
        enable   <= cfg_wdata[0];
        div_pend <= cfg_wdata[2:1];
      end
      // Only retune the divider while the slow clock owns the CPU.
      if (state == LS_RUN) cpuclk_div_sel <= div_pend;
    end

  always_ff @(posedge lsclk_in or negedge rst_b)
    if (!rst_b) begin
      state        <= LS_RUN;
      hsclk_sel    <= 1'b0;
      hs_active    <= 1'b0;
      switching    <= 1'b0;
      timeout_err  <= 1'b0;
      switch_count <= 8'd0;
      timer        <= 8'd0;
      dwell        <= 4'd0;
    end else begin
      if (cfg_wr) timeout_err <= 1'b0;
      case (state)
        LS_RUN:
          if (enable && fast_req && !slow_force) begin
            state     <= TO_HS;
            hsclk_sel <= 1'b1;
            switching <= 1'b1;
            timer     <= TMO;
          end
        TO_HS: begin
          if (timer != 8'd0) timer <= timer - 8'd1;
          if (hs_ack && !lsclk_selected) begin
            state     <= HS_RUN;
            switching <= 1'b0;
            hs_active <= 1'b1;
            dwell     <= DWELL;
            if (switch_count != 8'hff) switch_count <= switch_count + 8'd1;
          end else if (slow_force || !enable || tmr_exp) begin
            if (!(slow_force || !enable)) timeout_err <= 1'b1;
            state     <= TO_LS;
            hsclk_sel <= 1'b0;
            timer     <= TMO;
          end
        end
        HS_RUN: begin
          if (dwell != 4'd0) dwell <= dwell - 4'd1;
          if (slow_force || !enable || (!fast_req && dwell == 4'd0)) begin
            state     <= TO_LS;
            hsclk_sel <= 1'b0;
            hs_active <= 1'b0;
            switching <= 1'b1;
            timer     <= TMO;
          end
        end
        TO_LS: begin
          // A stuck return keeps re-flagging the error here; TO_LS is the only safe place to wait.
          if (timer != 8'd0) timer <= timer - 8'd1;
          if (!hs_ack && lsclk_selected) begin
            state     <= LS_RUN;
            switching <= 1'b0;
          end else if (tmr_exp) begin
            timeout_err <= 1'b1;
          end
        end
        default: state <= LS_RUN;
      endcase
    end

endmodule

// File: tb/tb_cpuclk_sched.sv
// Directed bench for cpuclk_sched with a small clock-switch model that acks after sw_dly cycles.
module tb_cpuclk_sched;

  logic       lsclk_in, rst_b, fast_req, slow_force, cfg_wr;
  logic [2:0] cfg_wdata;
  logic       hsclk_selected, lsclk_selected;
  logic       hsclk_sel, hs_active, switching, timeout_err;
  logic [1:0] cpuclk_div_sel;
  logic [7:0] switch_count;

  int   nvec = 0;
  int   nerr = 0;
  bit   sw_en = 1'b1;
  int   sw_dly = 3;
  int   sw_cnt = 0;
  logic hs_state = 1'b0;

  cpuclk_sched #(.MIN_DWELL(4), .ACK_TIMEOUT(15), .DEFAULT_DIV(2'b00)) dut (
    .lsclk_in(lsclk_in), .rst_b(rst_b), .fast_req(fast_req), .slow_force(slow_force),
    .cfg_wr(cfg_wr), .cfg_wdata(cfg_wdata), .hsclk_selected(hsclk_selected),
    .lsclk_selected(lsclk_selected), .hsclk_sel(hsclk_sel), .cpuclk_div_sel(cpuclk_div_sel),
    .hs_active(hs_active), .switching(switching), .timeout_err(timeout_err),
    .switch_count(switch_count)
  );

  initial begin
    lsclk_in = 1'b0;
    forever #5 lsclk_in = ~lsclk_in;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge lsclk_in);
    #1;
    if (sw_en) begin
      if (hsclk_sel !== hs_state) begin
        sw_cnt++;
        if (sw_cnt >= sw_dly) begin
          hs_state       = hsclk_sel;
          hsclk_selected = hs_state;
          lsclk_selected = !hs_state;
          sw_cnt         = 0;
        end
      end else sw_cnt = 0;
    end
  endtask

  function automatic logic sig(input int sel);
    case (sel)
      0:       return hs_active;
      1:       return switching;
      default: return timeout_err;
    endcase
  endfunction

  task automatic wait_for(input int sel, input logic want, input int bound, input string tag,
                          output int n);
    n = 0;
    while (sig(sel) !== want && n < bound) begin
      tick();
      n++;
    end
    if (sig(sel) !== want) chk({tag, "_timed_out"}, 32'd1, 32'd0);
  endtask

  task automatic wr_cfg(input logic [2:0] d);
    cfg_wr = 1'b1; cfg_wdata = d;
    tick();
    cfg_wr = 1'b0;
  endtask

  initial begin
    int   n;
    logic seen;
    rst_b = 1'b0; fast_req = 1'b1; slow_force = 1'b0; cfg_wr = 1'b0; cfg_wdata = 3'b000;
    hsclk_selected = 1'b0; lsclk_selected = 1'b1;
    #12 rst_b = 1'b1;

    // Disabled after reset: fast_req alone never requests the fast clock.
    seen = 1'b0;
    for (int i = 0; i < 50; i++) begin tick(); seen |= hsclk_sel; end
    chk("idle_hs_sel", 32'(seen), 32'd0);
    chk("idle_div", 32'(cpuclk_div_sel), 32'd0);
    chk("idle_flags", {hs_active, switching, timeout_err}, 32'd0);
    chk("idle_count", 32'(switch_count), 32'd0);

    // Enable with div=01: request one edge after enable lands.
    wr_cfg(3'b011);
    chk("en_no_req_yet", 32'(hsclk_sel), 32'd0);
    tick();
    chk("req_hs_sel", 32'(hsclk_sel), 32'd1);
    chk("req_switching", 32'(switching), 32'd1);
    chk("req_div", 32'(cpuclk_div_sel), 32'd1);
    wait_for(0, 1'b1, 20, "hs_entry", n);
    chk("hs_entry_lat", n, 32'd5);
    chk("hs_count1", 32'(switch_count), 32'd1);
    chk("hs_switching0", 32'(switching), 32'd0);
    fast_req = 1'b0;
    wait_for(0, 1'b0, 20, "dwell_exit", n);
    chk("dwell_exit_lat", n, 32'd5);
    chk("dwell_exit_sel", {hsclk_sel, switching}, 32'b01);
    wait_for(1, 1'b0, 20, "ls_return", n);
    chk("ls_return_lat", n, 32'd5);

    // slow_force in HS_RUN while dwell is still 3 leaves immediately.
    fast_req = 1'b1;
    tick();
    wait_for(0, 1'b1, 20, "hs_entry2", n);
    tick();
    slow_force = 1'b1;
    tick();
    chk("force_sel", 32'(hsclk_sel), 32'd0);
    chk("force_state", {hs_active, switching}, 32'b01);
    chk("hs_count2", 32'(switch_count), 32'd2);
    wait_for(1, 1'b0, 20, "force_return", n);
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin tick(); seen |= hsclk_sel; end
    chk("force_blocks_fast", 32'(seen), 32'd0);
    slow_force = 1'b0;

    // Divider written in HS_RUN waits for the first LS_RUN cycle.
    wait_for(0, 1'b1, 20, "hs_entry3", n);
    wr_cfg(3'b101);
    fast_req = 1'b0;
    chk("div_hold_hs", 32'(cpuclk_div_sel), 32'd1);
    wait_for(0, 1'b0, 20, "div_exit", n);
    wait_for(1, 1'b0, 20, "div_return", n);
    chk("div_hold_ls_entry", 32'(cpuclk_div_sel), 32'd1);
    tick();
    chk("div_applied", 32'(cpuclk_div_sel), 32'd2);

    // Switch never acks: timeout after 15 edges, then a clear racing a new timeout.
    sw_en = 1'b0;
    fast_req = 1'b1;
    tick();
    chk("tmo_req", 32'(hsclk_sel), 32'd1);
    wait_for(2, 1'b1, 40, "tmo", n);
    chk("tmo_lat", n, 32'd15);
    chk("tmo_state", {hsclk_sel, switching}, 32'b01);
    tick();
    chk("tmo_back_ls", 32'(switching), 32'd0);
    tick();
    chk("tmo_rereq", 32'(hsclk_sel), 32'd1);
    tick(); tick();
    wr_cfg(3'b101);
    chk("tmo_clear", 32'(timeout_err), 32'd0);
    for (int i = 0; i < 11; i++) tick();
    chk("tmo_pre_race", 32'(timeout_err), 32'd0);
    wr_cfg(3'b101);
    chk("tmo_set_wins", 32'(timeout_err), 32'd1);
    chk("tmo2_sel", 32'(hsclk_sel), 32'd0);
    fast_req = 1'b0;
    sw_en = 1'b1;
    wait_for(1, 1'b0, 20, "tmo_return", n);
    wr_cfg(3'b101);
    chk("tmo_cleared", 32'(timeout_err), 32'd0);

    // Round trips until switch_count saturates.
    for (int i = 0; i < 300; i++) begin
      fast_req = 1'b1;
      wait_for(0, 1'b1, 30, "rt_enter", n);
      fast_req = 1'b0;
      wait_for(0, 1'b0, 30, "rt_exit", n);
      wait_for(1, 1'b0, 30, "rt_ls", n);
      if (i == 96) chk("count_100", 32'(switch_count), 32'd100);
    end
    chk("count_sat", 32'(switch_count), 32'd255);

    // Asynchronous reset while in TO_HS.
    fast_req = 1'b1;
    tick();
    chk("rst_pre_to_hs", {hsclk_sel, switching}, 32'b11);
    #2 rst_b = 1'b0;
    #1;
    chk("rst_sel", 32'(hsclk_sel), 32'd0);
    chk("rst_flags", {hs_active, switching, timeout_err}, 32'd0);
    chk("rst_count", 32'(switch_count), 32'd0);
    chk("rst_div", 32'(cpuclk_div_sel), 32'd0);
    hs_state = 1'b0; sw_cnt = 0; hsclk_selected = 1'b0; lsclk_selected = 1'b1;
    #3 rst_b = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin tick(); seen |= hsclk_sel; end
    chk("rst_enable_off", 32'(seen), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
